// File: rtl/sparse_serializer.sv
// sparse_serializer: captures one compacted frame (value/column pairs plus a
// count) and replays it one pair per beat on a valid/ready stream, flagging
// the final beat. A zero-count frame yields a single empty beat with
// out_empty set so downstream framing never loses a frame boundary.
// Optional feature macro: SPARSE_SER_FRAME_ID_EN adds an 8-bit out_frame_id
// that counts completed frames (mod 256).
// W_OUT must be at least 2.
module sparse_serializer #(
  parameter int W_OUT         = 128,
  parameter int SIZE_val_DATA = 8,
  parameter int SIZE_count    = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [W_OUT-1:0][SIZE_val_DATA-1:0]   in_val,
  input  logic [W_OUT-1:0][SIZE_count-1:0]      in_col,
  input  logic [SIZE_count-1:0]                 in_count,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIZE_val_DATA-1:0]              out_val,
  output logic [SIZE_count-1:0]                 out_col,
  output logic                                  out_last,
`ifdef SPARSE_SER_FRAME_ID_EN
  output logic [7:0]                            out_frame_id,
`endif
  output logic                                  out_empty
);

  // One extra bit so a full frame (count == W_OUT) is representable.
  localparam int IDX_W = $clog2(W_OUT) + 1;
  localparam int SEL_W = $clog2(W_OUT);
  localparam int CMP_W = (SIZE_count > IDX_W) ? SIZE_count : IDX_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [IDX_W-1:0]                     eff_count;
  logic [W_OUT-1:0][SIZE_val_DATA-1:0]  val_buf;
  logic [W_OUT-1:0][SIZE_count-1:0]     col_buf;

  logic [IDX_W-1:0]                     next_idx;
  logic [SEL_W-1:0]                     next_sel;
  logic [IDX_W-1:0]                     cap_count;
  logic                                 capture;
  logic                                 beat_xfer;

  // Clamp the requested entry count to the capture array depth.
  function automatic logic [IDX_W-1:0] sat_count(input logic [SIZE_count-1:0] cnt);
    logic [CMP_W-1:0] wide;
    wide = CMP_W'(cnt);
    if (wide > CMP_W'(W_OUT)) return IDX_W'(W_OUT);
    return IDX_W'(wide);
  endfunction

  assign next_idx  = idx + IDX_W'(1);
  // Only consulted while next_idx < eff_count <= W_OUT, so the top bit is zero.
  assign next_sel  = next_idx[SEL_W-1:0];
  assign cap_count = sat_count(in_count);
  assign capture   = (state == IDLE) && in_valid && in_ready;
  assign beat_xfer = out_valid && out_ready;

  // Frame buffer: loaded only on the capture cycle, untouched during SEND.
  always_ff @(posedge clk) begin
    if (capture) begin
      val_buf <= in_val;
      col_buf <= in_col;
    end
  end

  // Control FSM with registered handshake and beat outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      eff_count <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (capture) begin
            state     <= SEND;
            in_ready  <= 1'b0;
            idx       <= '0;
            eff_count <= cap_count;
            out_valid <= 1'b1;
            // Entry 0 is taken straight from the inputs so it appears one
            // cycle after capture.
            if (cap_count == '0) begin
              out_val   <= '0;
              out_col   <= '0;
              out_last  <= 1'b1;
              out_empty <= 1'b1;
            end else begin
              out_val   <= in_val[0];
              out_col   <= in_col[0];
              out_last  <= (cap_count == IDX_W'(1));
              out_empty <= 1'b0;
            end
          end
        end
        SEND: begin
          if (beat_xfer) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_empty <= 1'b0;
            end else begin
              idx      <= next_idx;
              out_val  <= val_buf[next_sel];
              out_col  <= col_buf[next_sel];
              out_last <= (next_idx == eff_count - IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPARSE_SER_FRAME_ID_EN
  // Frame counter advances on each last-beat transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_frame_id <= '0;
    end else if (beat_xfer && out_last) begin
      out_frame_id <= out_frame_id + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sparse_serializer.sv
// Self-checking bench for sparse_serializer. Frames are expanded into an
// expected beat queue from the serialization rules (clamp, empty beat,
// last flag) and compared against the stream every cycle out_valid is due.
// Honours SPARSE_SER_FRAME_ID_EN when defined.
module tb_sparse_serializer;

  localparam int W   = 128;
  localparam int SZV = 8;
  localparam int SZC = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0][SZV-1:0] in_val;
  logic [W-1:0][SZC-1:0] in_col;
  logic [SZC-1:0]        in_count;
  logic                  out_valid;
  logic                  out_ready;
  logic [SZV-1:0]        out_val;
  logic [SZC-1:0]        out_col;
  logic                  out_last;
  logic                  out_empty;
`ifdef SPARSE_SER_FRAME_ID_EN
  logic [7:0]            out_frame_id;
`endif

  sparse_serializer #(.W_OUT(W), .SIZE_val_DATA(SZV), .SIZE_count(SZC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_col    (in_col),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_col   (out_col),
    .out_last  (out_last),
`ifdef SPARSE_SER_FRAME_ID_EN
    .out_frame_id (out_frame_id),
`endif
    .out_empty (out_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    logic [7:0] c;
    logic       l;
    logic       e;
  } beat_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  fvals [W];
  logic [7:0]  fcols [W];
  int          exp_fid = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < W; i++) begin
      in_val[i] = 8'($urandom);
      in_col[i] = 8'($urandom);
    end
    in_count = 8'($urandom);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_val", out_val, 0);
    check_eq("rst_out_col", out_col, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_empty", out_empty, 0);
`ifdef SPARSE_SER_FRAME_ID_EN
    check_eq("rst_frame_id", out_frame_id, 0);
`endif
  endtask

  // Entered and left just after a falling edge.
  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    exp_fid = 0;
    @(negedge clk);
    check_eq("ready_after_reset", in_ready, 1);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 4 cycles on stall_beat.
  // abort_at >= 0 asserts reset while that beat is presented.
  task automatic run_frame(input int cnt, input int mode, input int stall_beat, input int abort_at);
    beat_t q[$];
    beat_t b;
    int    n;
    int    cyc;
    int    beat_no;
    int    stall_cnt;
    bit    aborted;
    bit    r;

    n = (cnt > W) ? W : cnt;
    if (n == 0) begin
      b.v = 0; b.c = 0; b.l = 1; b.e = 1;
      q.push_back(b);
    end else begin
      for (int i = 0; i < n; i++) begin
        b.v = fvals[i]; b.c = fcols[i]; b.l = (i == n - 1); b.e = 0;
        q.push_back(b);
      end
    end

    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("in_ready_wait", in_ready, 1);

    for (int i = 0; i < W; i++) begin
      in_val[i] = fvals[i];
      in_col[i] = fcols[i];
    end
    in_count  = 8'(cnt);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);

    cyc = 0; beat_no = 0; stall_cnt = 0; aborted = 0;
    while (q.size() > 0 && cyc < 3000) begin
      b = q[0];
      check_eq("out_valid", out_valid, 1);
      check_eq("out_val", out_val, b.v);
      check_eq("out_col", out_col, b.c);
      check_eq("out_last", out_last, b.l);
      check_eq("out_empty", out_empty, b.e);
`ifdef SPARSE_SER_FRAME_ID_EN
      check_eq("frame_id", out_frame_id, exp_fid % 256);
`endif
      if (beat_no == abort_at) begin
        aborted = 1;
        break;
      end
      case (mode)
        1: r = ($urandom_range(0, 2) != 0);
        2: begin
          if (beat_no == stall_beat && stall_cnt < 4) begin
            r = 0;
            stall_cnt++;
          end else begin
            r = 1;
          end
        end
        default: r = 1;
      endcase
      // Input side is noise during SEND and must be ignored.
      in_valid  = 1'($urandom);
      scramble_inputs();
      out_ready = r;
      if (r) begin
        void'(q.pop_front());
        beat_no++;
        if (b.l) exp_fid++;
      end
      @(negedge clk);
      cyc++;
    end

    if (aborted) begin
      apply_reset();
    end else begin
      check_eq("frame_timeout", (q.size() == 0), 1);
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("in_ready_return", in_ready, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < W; i++) begin
      fvals[i] = 8'($urandom);
      fcols[i] = 8'($urandom_range(0, 127));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_val    = '0;
    in_col    = '0;
    in_count  = '0;
    for (int i = 0; i < W; i++) begin
      fvals[i] = 0;
      fcols[i] = 0;
    end

    apply_reset();

    fvals[0] = 5; fvals[1] = 9; fvals[2] = 2;
    fcols[0] = 1; fcols[1] = 4; fcols[2] = 127;
    run_frame(3, 0, -1, -1);

    run_frame(0, 0, -1, -1);

    fill_random(3);
    run_frame(3, 2, 1, -1);

    fill_random(W);
    run_frame(W, 0, -1, -1);
    fill_random(W);
    run_frame(200, 1, -1, -1);

    fill_random(5);
    run_frame(5, 0, -1, 2);
    fill_random(5);
    run_frame(5, 0, -1, -1);

    for (int k = 0; k < 12; k++) begin
      fill_random(W);
      if (k % 5 == 4) run_frame($urandom_range(120, 255), 1, -1, -1);
      else            run_frame($urandom_range(0, 20), 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
